// File: rtl/pixel_hier_pkg.sv
// Shared types and helpers for the pixel arbitration hierarchy.
// Level-1 schedulers build their event addresses with pack_evt_addr.
package pixel_hier_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_GNT = 2'b01,
    EVENT    = 2'b10,
    CLEAR    = 2'b11
  } sched_state_t;

  localparam int PIX_ADDR_W = 2;
  localparam int MAX_GRP_W  = 4;
  localparam int MAX_EVT_W  = MAX_GRP_W + 2 * PIX_ADDR_W;

  // Group index sits in the top bits, so truncating the result
  // to a narrower group width keeps {grp, x, y} intact.
  function automatic logic [MAX_EVT_W-1:0] pack_evt_addr(
    input logic [MAX_GRP_W-1:0]  grp,
    input logic [PIX_ADDR_W-1:0] x,
    input logic [PIX_ADDR_W-1:0] y
  );
    return {grp, x, y};
  endfunction

endpackage

// File: rtl/rr_group_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping around. NUM must be a power of two so the index wraps naturally.
module rr_group_picker #(
  parameter int NUM   = 4,
  parameter int IDX_W = $clog2(NUM)
) (
  input  logic [NUM-1:0]   req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] sel,
  output logic             found
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_group_scheduler.sv
// Level-1 scheduler: shares one event port between NUM_GROUPS level-0 arbiters,
// granting groups round-robin and clearing the served pixel after each event.
module pixel_group_scheduler
  import pixel_hier_pkg::*;
#(
  parameter int NUM_GROUPS  = 4,
  parameter int GRP_W       = $clog2(NUM_GROUPS),
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_GROUPS-1:0]                 grp_req_i,
  input  logic [NUM_GROUPS-1:0]                 grp_gnt_i,
  input  logic [NUM_GROUPS-1:0][PIX_ADDR_W-1:0] grp_x_add_i,
  input  logic [NUM_GROUPS-1:0][PIX_ADDR_W-1:0] grp_y_add_i,
  output logic [NUM_GROUPS-1:0]                 grp_enable_o,
  output logic [NUM_GROUPS-1:0]                 clr_o,
  output logic [PIX_ADDR_W-1:0]                 clr_x_o,
  output logic [PIX_ADDR_W-1:0]                 clr_y_o,
  output logic                                  evt_valid_o,
  input  logic                                  evt_ready_i,
  output logic [GRP_W+2*PIX_ADDR_W-1:0]         evt_addr_o,
  output logic                                  timeout_o,
  output logic                                  busy_o
);

  localparam int ADDR_W = GRP_W + 2 * PIX_ADDR_W;
  localparam int TCNT_W = 8;

  sched_state_t              state_q, state_d;
  logic [GRP_W-1:0]          sel_q, sel_d;
  logic [GRP_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [TCNT_W-1:0]         tcnt_q, tcnt_d;
  logic [NUM_GROUPS-1:0]     grp_enable_q, grp_enable_d;
  logic [NUM_GROUPS-1:0]     clr_q, clr_d;
  logic [PIX_ADDR_W-1:0]     clr_x_q, clr_x_d;
  logic [PIX_ADDR_W-1:0]     clr_y_q, clr_y_d;
  logic                      evt_valid_q, evt_valid_d;
  logic [ADDR_W-1:0]         evt_addr_q, evt_addr_d;
  logic                      timeout_q, timeout_d;
  logic                      busy_q, busy_d;

  logic [GRP_W-1:0]          pick_sel;
  logic                      pick_found;

  rr_group_picker #(
    .NUM   (NUM_GROUPS),
    .IDX_W (GRP_W)
  ) u_picker (
    .req   (grp_req_i),
    .ptr   (rr_ptr_q),
    .sel   (pick_sel),
    .found (pick_found)
  );

  // Outputs are computed one cycle ahead so every port comes straight off a flop.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    tcnt_d       = tcnt_q;
    grp_enable_d = grp_enable_q;
    clr_d        = '0;
    clr_x_d      = '0;
    clr_y_d      = '0;
    evt_valid_d  = evt_valid_q;
    evt_addr_d   = evt_addr_q;
    timeout_d    = 1'b0;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d        = pick_sel;
          tcnt_d       = '0;
          grp_enable_d = NUM_GROUPS'(1) << pick_sel;
          busy_d       = 1'b1;
          state_d      = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (grp_gnt_i[sel_q]) begin
          evt_addr_d  = ADDR_W'(pack_evt_addr(MAX_GRP_W'(sel_q),
                                              grp_x_add_i[sel_q],
                                              grp_y_add_i[sel_q]));
          evt_valid_d = 1'b1;
          state_d     = EVENT;
        end else if (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_d    = 1'b1;
          rr_ptr_d     = sel_q + GRP_W'(1);
          grp_enable_d = '0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      EVENT: begin
        if (evt_valid_q && evt_ready_i) begin
          evt_valid_d  = 1'b0;
          grp_enable_d = '0;
          clr_d        = NUM_GROUPS'(1) << sel_q;
          clr_x_d      = evt_addr_q[2*PIX_ADDR_W-1:PIX_ADDR_W];
          clr_y_d      = evt_addr_q[PIX_ADDR_W-1:0];
          state_d      = CLEAR;
        end
      end
      CLEAR: begin
        rr_ptr_d = sel_q + GRP_W'(1);
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      rr_ptr_q     <= '0;
      tcnt_q       <= '0;
      grp_enable_q <= '0;
      clr_q        <= '0;
      clr_x_q      <= '0;
      clr_y_q      <= '0;
      evt_valid_q  <= 1'b0;
      evt_addr_q   <= '0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
      tcnt_q       <= tcnt_d;
      grp_enable_q <= grp_enable_d;
      clr_q        <= clr_d;
      clr_x_q      <= clr_x_d;
      clr_y_q      <= clr_y_d;
      evt_valid_q  <= evt_valid_d;
      evt_addr_q   <= evt_addr_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
    end
  end

  assign grp_enable_o = grp_enable_q;
  assign clr_o        = clr_q;
  assign clr_x_o      = clr_x_q;
  assign clr_y_o      = clr_y_q;
  assign evt_valid_o  = evt_valid_q;
  assign evt_addr_o   = evt_addr_q;
  assign timeout_o    = timeout_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_pixel_group_scheduler.sv
// Directed self-checking bench for pixel_group_scheduler; expected event
// addresses are queued when grants are driven and popped on each handshake.
module tb_pixel_group_scheduler;

  localparam int NG = 4;
  localparam int GW = 2;

  logic              clk;
  logic              rst_n;
  logic [NG-1:0]     grpReq;
  logic [NG-1:0]     grpGnt;
  logic [NG-1:0][1:0] grpX;
  logic [NG-1:0][1:0] grpY;
  logic [NG-1:0]     grpEnable;
  logic [NG-1:0]     clr;
  logic [1:0]        clrX;
  logic [1:0]        clrY;
  logic              evtValid;
  logic              evtReady;
  logic [GW+3:0]     evtAddr;
  logic              timeoutPulse;
  logic              busy;

  int compareCount = 0;
  int failCount    = 0;
  int cycleCount   = 0;
  logic [GW+3:0] expQ[$];

  pixel_group_scheduler #(
    .NUM_GROUPS  (NG),
    .TIMEOUT_CYC (15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .grp_req_i    (grpReq),
    .grp_gnt_i    (grpGnt),
    .grp_x_add_i  (grpX),
    .grp_y_add_i  (grpY),
    .grp_enable_o (grpEnable),
    .clr_o        (clr),
    .clr_x_o      (clrX),
    .clr_y_o      (clrY),
    .evt_valid_o  (evtValid),
    .evt_ready_i  (evtReady),
    .evt_addr_o   (evtAddr),
    .timeout_o    (timeoutPulse),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NG-1:0] req, input logic [NG-1:0] gnt, input logic ready);
    grpReq   = req;
    grpGnt   = gnt;
    evtReady = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_enable"},  32'(grpEnable),    0);
    checkOutput({tag, "_clr"},     32'(clr),          0);
    checkOutput({tag, "_clrx"},    32'(clrX),         0);
    checkOutput({tag, "_clry"},    32'(clrY),         0);
    checkOutput({tag, "_valid"},   32'(evtValid),     0);
    checkOutput({tag, "_addr"},    32'(evtAddr),      0);
    checkOutput({tag, "_timeout"}, 32'(timeoutPulse), 0);
    checkOutput({tag, "_busy"},    32'(busy),         0);
  endtask

  // Scoreboard: every handshake must match the oldest queued event.
  always @(negedge clk) begin
    if (!rst_n && evtValid && evtReady) begin
      checkOutput("evt_expected", 32'(expQ.size() != 0), 1);
      if (expQ.size() != 0) checkOutput("evt_addr_sb", 32'(evtAddr), 32'(expQ.pop_front()));
    end
  end

  initial begin
    logic [GW+3:0] holdAddr;
    int lastCycle;
    bit found;

    rst_n = 1'b1;
    applyStimulus('0, '0, 1'b0);
    grpX = '0;
    grpY = '0;
    tick();
    tick();
    checkIdleOutputs("reset");
    rst_n = 1'b0;

    // Single request: group 2 grants two cycles after enable
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    grpX[2] = 2'd1;
    grpY[2] = 2'd3;
    tick();
    checkOutput("single_enable", 32'(grpEnable), 32'b0100);
    checkOutput("single_busy", 32'(busy), 1);
    tick();
    tick();
    checkOutput("single_no_valid_yet", 32'(evtValid), 0);
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    expQ.push_back(6'b10_01_11);
    tick();
    checkOutput("single_valid", 32'(evtValid), 1);
    checkOutput("single_addr", 32'(evtAddr), 32'b10_01_11);
    checkOutput("single_enable_hold", 32'(grpEnable), 32'b0100);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("single_clr", 32'(clr), 32'b0100);
    checkOutput("single_clrx", 32'(clrX), 1);
    checkOutput("single_clry", 32'(clrY), 3);
    checkOutput("single_clr_valid_low", 32'(evtValid), 0);
    checkOutput("single_clr_enable_low", 32'(grpEnable), 0);
    tick();
    checkOutput("single_clr_once", 32'(clr), 0);
    checkOutput("single_busy_end", 32'(busy), 0);

    // Fairness from a fresh pointer: all groups request and grant
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    for (int g = 0; g < NG; g++) begin
      grpX[g] = 2'(g);
      grpY[g] = 2'(3 - g);
    end
    for (int k = 0; k < 5; k++) expQ.push_back({2'(k % 4), 2'(k % 4), 2'(3 - (k % 4))});
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    lastCycle = 0;
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        if (evtValid) found = 1'b1;
        else tick();
      end
      checkOutput($sformatf("fair_valid_%0d", k), 32'(found), 1);
      checkOutput($sformatf("fair_enable_%0d", k), 32'(grpEnable), 32'(1 << (k % 4)));
      if (k > 0) checkOutput($sformatf("fair_spacing_%0d", k), 32'(cycleCount - lastCycle), 4);
      lastCycle = cycleCount;
      if (k == 4) applyStimulus(4'b0000, 4'b0000, 1'b1);
      tick();
    end
    tick();
    checkOutput("fair_busy_end", 32'(busy), 0);

    // Backpressure: pointer now at 1, hold ready low for 5 EVENT cycles
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    tick();
    checkOutput("bp_enable", 32'(grpEnable), 32'b0010);
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    expQ.push_back(6'b01_01_10);
    tick();
    holdAddr = 6'b01_01_10;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_valid_%0d", i), 32'(evtValid), 1);
      checkOutput($sformatf("bp_addr_%0d", i), 32'(evtAddr), 32'(holdAddr));
      checkOutput($sformatf("bp_no_clr_%0d", i), 32'(clr), 0);
      tick();
    end
    checkOutput("bp_still_valid", 32'(evtValid), 1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("bp_clr", 32'(clr), 32'b0010);
    checkOutput("bp_valid_low", 32'(evtValid), 0);
    tick();

    // Timeout: pointer at 2, only group 1 requests and never grants
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    tick();
    for (int i = 1; i < 15; i++) begin
      checkOutput($sformatf("to_wait_%0d", i), 32'(timeoutPulse), 0);
      checkOutput($sformatf("to_enable_%0d", i), 32'(grpEnable), 32'b0010);
      tick();
    end
    checkOutput("to_last_wait_busy", 32'(busy), 1);
    checkOutput("to_last_wait_pulse", 32'(timeoutPulse), 0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("to_pulse", 32'(timeoutPulse), 1);
    checkOutput("to_busy", 32'(busy), 0);
    checkOutput("to_enable_off", 32'(grpEnable), 0);
    checkOutput("to_no_valid", 32'(evtValid), 0);
    tick();
    checkOutput("to_pulse_once", 32'(timeoutPulse), 0);
    // Pointer must have moved to 2: groups 0,1,2 request, 2 wins
    applyStimulus(4'b0111, 4'b0000, 1'b1);
    tick();
    checkOutput("to_ptr_pick", 32'(grpEnable), 32'b0100);
    applyStimulus(4'b0111, 4'b0100, 1'b1);
    expQ.push_back(6'b10_10_01);
    tick();
    checkOutput("to_next_addr", 32'(evtAddr), 32'b10_10_01);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    tick();

    // Stray grant: pointer at 3, group 0 selected, group 3 grants first
    applyStimulus(4'b0001, 4'b1000, 1'b1);
    tick();
    checkOutput("stray_enable", 32'(grpEnable), 32'b0001);
    tick();
    checkOutput("stray_ignored", 32'(evtValid), 0);
    checkOutput("stray_still_wait", 32'(grpEnable), 32'b0001);
    applyStimulus(4'b0001, 4'b1001, 1'b1);
    expQ.push_back(6'b00_00_11);
    tick();
    checkOutput("stray_addr", 32'(evtAddr), 32'b00_00_11);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("stray_clr", 32'(clr), 32'b0001);
    tick();

    // Reset while an event is waiting on the consumer
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    tick();
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    tick();
    checkOutput("rst_mid_valid", 32'(evtValid), 1);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    tick();
    checkIdleOutputs("rst_mid");
    rst_n = 1'b0;
    evtReady = 1'b1;
    tick();
    checkOutput("rst_mid_no_clr", 32'(clr), 0);
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    tick();
    checkOutput("rst_mid_restart_grp0", 32'(grpEnable), 32'b0001);
    applyStimulus(4'b0000, 4'b0001, 1'b1);
    expQ.push_back(6'b00_00_11);
    tick();
    checkOutput("rst_mid_addr", 32'(evtAddr), 32'b00_00_11);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    checkOutput("rst_mid_clr", 32'(clr), 32'b0001);
    tick();

    checkOutput("queue_drained", 32'(expQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
